// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: fetch, decode, execute,
// memory and write-back sequencing with bus stall handling and halt on PC 0.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       waitrequest,
  input  logic       pc_zero,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       branch_ne,
  output logic [1:0] PCSource,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       active,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_EXEC_R    = 4'd2;
  localparam logic [3:0] S_WB_R      = 4'd3;
  localparam logic [3:0] S_EXEC_I    = 4'd4;
  localparam logic [3:0] S_WB_I      = 4'd5;
  localparam logic [3:0] S_MEM_ADDR  = 4'd6;
  localparam logic [3:0] S_MEM_READ  = 4'd7;
  localparam logic [3:0] S_MEM_WB    = 4'd8;
  localparam logic [3:0] S_MEM_WRITE = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [3:0] S_JUMP_REG  = 4'd12;
  localparam logic [3:0] S_HALT      = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       reg_write_s;
  logic       branch_ne_s;
  logic [1:0] pc_source_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       active_s;

  // Instruction class dispatch out of DECODE; unknown opcodes retire as NOPs.
  function automatic logic [3:0] decode_next(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] nxt;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_JR) begin
          nxt = S_JUMP_REG;
        end else begin
          nxt = S_EXEC_R;
        end
      end
      OP_LW, OP_SW:                                  nxt = S_MEM_ADDR;
      OP_BEQ, OP_BNE:                                nxt = S_BRANCH;
      OP_J:                                          nxt = S_JUMP;
      OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:   nxt = S_EXEC_I;
      default:                                       nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  // State register; reset forces FETCH asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode (ungated).
  always_comb begin
    state_d         = state_q;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'd0;
    alu_op_s        = 2'd0;
    iord_s          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    reg_write_s     = 1'b0;
    branch_ne_s     = 1'b0;
    pc_source_s     = 2'd0;
    reg_dst_s       = 1'b0;
    mem_to_reg_s    = 1'b0;
    active_s        = 1'b1;
    case (state_q)
      S_FETCH: begin
        if (pc_zero) begin
          state_d = S_HALT;
        end else begin
          mem_read_s  = 1'b1;
          alu_src_b_s = 2'd1;
          // IR and PC+4 are committed in the very cycle the bus accepts the read.
          if (!waitrequest) begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            state_d    = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DECODE: begin
        alu_src_b_s = 2'd3;
        state_d     = decode_next(opcode, funct);
      end
      S_EXEC_R: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'd2;
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
        alu_op_s    = 2'd3;
        state_d     = S_WB_I;
      end
      S_WB_I: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
        if (opcode == OP_LW) begin
          state_d = S_MEM_READ;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        iord_s     = 1'b1;
        mem_read_s = 1'b1;
        if (waitrequest) begin
          state_d = S_MEM_READ;
        end else begin
          state_d = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        iord_s      = 1'b1;
        mem_write_s = 1'b1;
        if (waitrequest) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'd1;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'd1;
        branch_ne_s     = (opcode == OP_BNE);
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_source_s = 2'd2;
        pc_write_s  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP_REG: begin
        pc_source_s = 2'd3;
        pc_write_s  = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        active_s = 1'b0;
        state_d  = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Output stage: everything is forced low while reset is held.
  always_comb begin
    if (!reset) begin
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'd0;
      ALUOp       = 2'd0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegWrite    = 1'b0;
      branch_ne   = 1'b0;
      PCSource    = 2'd0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      active      = 1'b0;
    end else begin
      ALUSrcA     = alu_src_a_s;
      ALUSrcB     = alu_src_b_s;
      ALUOp       = alu_op_s;
      IorD        = iord_s;
      MemRead     = mem_read_s;
      MemWrite    = mem_write_s;
      IRWrite     = ir_write_s;
      PCWrite     = pc_write_s;
      PCWriteCond = pc_write_cond_s;
      RegWrite    = reg_write_s;
      branch_ne   = branch_ne_s;
      PCSource    = pc_source_s;
      RegDst      = reg_dst_s;
      MemtoReg    = mem_to_reg_s;
      active      = active_s;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed instruction table, random instruction
// stream against an instruction-level expansion model, and reset/halt sequences.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic       active;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic       bne;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       m2r;
    logic       regw;
  } ctrl_t;

  typedef struct {
    logic       wr;
    logic       pz;
    logic [5:0] op;
    logic [5:0] fn;
    ctrl_t      exp;
  } vec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         wf;
    int         wm;
    logic [3:0] last_st;
    string      name;
  } dir_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       waitrequest = 1'b0;
  logic       pc_zero = 1'b0;
  logic       ALUSrcA, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic       RegWrite, branch_ne, RegDst, MemtoReg, active;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  ctrl_t      obs;
  vec_t       q[$];
  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [3:0] last_state = 4'd0;
  dir_t       tbl[12];
  logic [5:0] rand_ops[13];

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(rst_n), .opcode(opcode), .funct(funct),
    .waitrequest(waitrequest), .pc_zero(pc_zero),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .branch_ne(branch_ne),
    .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .active(active), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, active, ALUSrcA, ALUSrcB, ALUOp, IorD, MemRead, MemWrite,
                IRWrite, PCWrite, PCWriteCond, branch_ne, PCSource, RegDst,
                MemtoReg, RegWrite};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctrl_t base(input logic [3:0] st);
    ctrl_t c;
    c        = '0;
    c.state  = st;
    c.active = 1'b1;
    return c;
  endfunction

  task automatic push(input logic w, input logic pz, input logic [5:0] op,
                      input logic [5:0] fn, input ctrl_t e);
    vec_t v;
    v.wr  = w;
    v.pz  = pz;
    v.op  = op;
    v.fn  = fn;
    v.exp = e;
    q.push_back(v);
  endtask

  // Instruction-level model: expands one instruction into its per-cycle expectations.
  task automatic expand(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
    ctrl_t c;
    logic  is_lw;
    is_lw = (op == 6'h23);
    for (int i = 0; i < wf; i++) begin
      c = base(4'd0); c.mrd = 1'b1; c.srcb = 2'd1;
      push(1'b1, 1'b0, op, fn, c);
    end
    c = base(4'd0); c.mrd = 1'b1; c.srcb = 2'd1; c.irw = 1'b1; c.pcw = 1'b1;
    push(1'b0, 1'b0, op, fn, c);
    c = base(4'd1); c.srcb = 2'd3;
    push(rb(), rb(), op, fn, c);
    if (op == 6'h00 && fn == 6'h08) begin
      c = base(4'd12); c.pcsrc = 2'd3; c.pcw = 1'b1;
      push(rb(), rb(), op, fn, c);
    end else if (op == 6'h00) begin
      c = base(4'd2); c.srca = 1'b1; c.aluop = 2'd2;
      push(rb(), rb(), op, fn, c);
      c = base(4'd3); c.regdst = 1'b1; c.regw = 1'b1;
      push(rb(), rb(), op, fn, c);
    end else if (op == 6'h23 || op == 6'h2b) begin
      c = base(4'd6); c.srca = 1'b1; c.srcb = 2'd2;
      push(rb(), rb(), op, fn, c);
      c = base(is_lw ? 4'd7 : 4'd9); c.iord = 1'b1;
      if (is_lw) c.mrd = 1'b1;
      else c.mwr = 1'b1;
      for (int i = 0; i < wm; i++) push(1'b1, rb(), op, fn, c);
      push(1'b0, rb(), op, fn, c);
      if (is_lw) begin
        c = base(4'd8); c.m2r = 1'b1; c.regw = 1'b1;
        push(rb(), rb(), op, fn, c);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      c = base(4'd10); c.srca = 1'b1; c.aluop = 2'd1; c.pcwc = 1'b1;
      c.pcsrc = 2'd1; c.bne = (op == 6'h05);
      push(rb(), rb(), op, fn, c);
    end else if (op == 6'h02) begin
      c = base(4'd11); c.pcsrc = 2'd2; c.pcw = 1'b1;
      push(rb(), rb(), op, fn, c);
    end else if (op == 6'h09 || op == 6'h0a || op == 6'h0c || op == 6'h0d || op == 6'h0e) begin
      c = base(4'd4); c.srca = 1'b1; c.srcb = 2'd2; c.aluop = 2'd3;
      push(rb(), rb(), op, fn, c);
      c = base(4'd5); c.regw = 1'b1;
      push(rb(), rb(), op, fn, c);
    end
  endtask

  task automatic check(input ctrl_t e, input string tag);
    vec_cnt++;
    last_state = obs.state;
    if (obs !== e) begin
      err_cnt++;
      $display("FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
               tag, obs.state, obs, e.state, e);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    waitrequest = v.wr;
    pc_zero     = v.pz;
    opcode      = v.op;
    funct       = v.fn;
    #2;
    check(v.exp, tag);
  endtask

  task automatic run_queue(input string tag);
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      apply(v, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_t zero_c;
    ctrl_t c;
    zero_c = '0;

    tbl[0]  = '{6'h00, 6'h21, 0, 0, 4'd3,  "addu"};
    tbl[1]  = '{6'h00, 6'h25, 2, 0, 4'd3,  "or_fetch_stall"};
    tbl[2]  = '{6'h23, 6'h00, 0, 2, 4'd8,  "lw_stall"};
    tbl[3]  = '{6'h2b, 6'h11, 1, 1, 4'd9,  "sw_stall"};
    tbl[4]  = '{6'h05, 6'h00, 0, 0, 4'd10, "bne"};
    tbl[5]  = '{6'h04, 6'h3f, 0, 0, 4'd10, "beq"};
    tbl[6]  = '{6'h00, 6'h08, 0, 0, 4'd12, "jr"};
    tbl[7]  = '{6'h02, 6'h08, 0, 0, 4'd11, "j"};
    tbl[8]  = '{6'h0d, 6'h00, 1, 0, 4'd5,  "ori"};
    tbl[9]  = '{6'h08, 6'h00, 0, 0, 4'd1,  "addi_nop"};
    tbl[10] = '{6'h0a, 6'h08, 0, 0, 4'd5,  "slti"};
    tbl[11] = '{6'h0b, 6'h00, 0, 0, 4'd1,  "sltiu_nop"};

    rand_ops = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h3f};

    // Reset held low for three cycles: everything gated off.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      waitrequest = 1'b0;
      pc_zero     = 1'b0;
      opcode      = 6'($urandom_range(0, 63));
      #2;
      check(zero_c, "reset_hold");
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      expand(tbl[i].op, tbl[i].fn, tbl[i].wf, tbl[i].wm);
      run_queue(tbl[i].name);
      vec_cnt++;
      if (last_state !== tbl[i].last_st) begin
        err_cnt++;
        $display("FAIL %s_final_state: got %0d expected %0d", tbl[i].name, last_state, tbl[i].last_st);
      end
    end

    for (int i = 0; i < 150; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = rand_ops[$urandom_range(0, 12)];
      if (op == 6'h3f) op = 6'($urandom_range(0, 63));
      fn = 6'($urandom_range(0, 63));
      if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'h08;
      expand(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
      run_queue("random");
    end

    // Reset asserted in the middle of a stalled load read.
    expand(6'h23, 6'h00, 0, 3);
    for (int i = 0; i < 4; i++) apply(q.pop_front(), "abort_pre");
    q.delete();
    #1 rst_n = 1'b0;
    #1 check(zero_c, "abort_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    expand(6'h2b, 6'h00, 0, 0);
    run_queue("after_abort");

    // Fetch from address 0 halts; HALT is absorbing until reset.
    c = base(4'd0);
    push(1'b0, 1'b1, 6'h00, 6'h21, c);
    c = '0;
    c.state = 4'd13;
    for (int i = 0; i < 20; i++) push(rb(), rb(), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), c);
    run_queue("halt");
    @(negedge clk);
    rst_n       = 1'b0;
    pc_zero     = 1'b0;
    waitrequest = 1'b0;
    #2 check(zero_c, "halt_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    expand(6'h00, 6'h21, 0, 0);
    run_queue("after_halt");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back. Each cycle it drives the ALU operand selects (ALUSrcA, and ALUSrcB into the ALU B-input mux), the PC, IR and register-file write enables, and the memory read/write strobes. Memory accesses are stretched by the bus `waitrequest` handshake. The FSM halts when a fetch targets address 0.

## Interface
Parameters:
- none (opcode/funct encodings fixed to MIPS I)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; low forces state FETCH and all control outputs 0
- `opcode`  in  6  IR[31:26]; valid from DECODE onward
- `funct`  in  6  IR[5:0]; valid from DECODE onward
- `waitrequest`  in  1  memory stall; 1 = current read/write not yet accepted
- `pc_zero`  in  1  PC register == 0
- `ALUSrcA`  out  1  0 = PC, 1 = register A
- `ALUSrcB`  out  2  0 = register B, 1 = constant 4, 2 = extended imm, 3 = extended imm << 2
- `ALUOp`  out  2  00 add, 01 subtract/compare, 10 decode funct, 11 decode opcode (immediate ops)
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemRead`, `MemWrite`  out  1 each  bus strobes
- `IRWrite`, `PCWrite`, `PCWriteCond`, `RegWrite`  out  1 each  write enables
- `branch_ne`  out  1  with PCWriteCond: 1 = take on not-equal, 0 = on equal
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register A
- `RegDst`  out  1  0 = rt, 1 = rd
- `MemtoReg`  out  1  0 = ALUOut, 1 = MDR
- `active`  out  1  1 until HALT entered
- `state`  out  4  current state encoding (debug)

## Operation
- States and encodings: FETCH 0, DECODE 1, EXEC_R 2, WB_R 3, EXEC_I 4, WB_I 5, MEM_ADDR 6, MEM_READ 7, MEM_WB 8, MEM_WRITE 9, BRANCH 10, JUMP 11, JUMP_REG 12, HALT 13.
- Codes 14 and 15 are unused and go to HALT on the next edge.
- Every control output not listed for a state is 0.
- FETCH:
  - If `pc_zero`: no strobes, next state HALT.
  - Otherwise: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=00, PCSource=00.
  - While `waitrequest`=1: stay in FETCH with IRWrite=PCWrite=0.
  - When `waitrequest`=0: IRWrite=1 and PCWrite=1 in that same cycle (Mealy), next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 000000 with funct 001000 (JR) → JUMP_REG; other 000000 → EXEC_R
  - 100011 LW, 101011 SW → MEM_ADDR
  - 000100 BEQ, 000101 BNE → BRANCH
  - 000010 J → JUMP
  - 001001, 001010, 001100, 001101, 001110 → EXEC_I
  - anything else → FETCH (NOP)
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=10 → WB_R.
- WB_R: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp=11 → WB_I.
- WB_I: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=00. Next MEM_READ if opcode is LW, else MEM_WRITE.
- MEM_READ: IorD=1, MemRead=1. Hold while `waitrequest`; → MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEM_WRITE: IorD=1, MemWrite=1. Hold while `waitrequest`; → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCWriteCond=1, PCSource=01, branch_ne=(opcode==000101) → FETCH.
- JUMP: PCSource=10, PCWrite=1 → FETCH.
- JUMP_REG: PCSource=11, PCWrite=1 → FETCH.
- HALT: all controls 0, `active`=0. Absorbing until `reset` goes low.
- No branch delay slot is modelled.

## Timing
- Reset:
  - `reset` low asynchronously sets state=FETCH.
  - While low, all control outputs and `active` are gated to 0 combinationally.
  - After `reset` releases, the first rising edge sees FETCH outputs (MemRead=1 unless `pc_zero`).
- Outputs are combinational from state, plus `waitrequest`/`pc_zero`/`opcode`/`funct`.
- Cycles per instruction with zero wait:
  - R-type and immediate: 4
  - LW: 5
  - SW: 4
  - BEQ/BNE, J, JR: 3
  - undefined opcode: 2
- Each `waitrequest` cycle adds 1 to FETCH, MEM_READ or MEM_WRITE.
- Strobes and address select hold constant across a stall; no enable pulses during a stall.
- Asserting `reset` mid-instruction aborts it; no partial write-back is issued after reset.
- `pc_zero` is sampled only in FETCH; it is ignored in all other states.

## Test plan
- Reset low for 3 cycles, then release with `pc_zero`=0, `waitrequest`=0 → all outputs 0 during reset; cycle 1 state=0, MemRead=1, ALUSrcB=1, IRWrite=PCWrite=1; cycle 2 state=1, ALUSrcB=3.
- ADDU (opcode 0, funct 100001), no stalls → states 0,1,2,3. EXEC_R has ALUSrcB=0, ALUOp=10; WB_R has RegWrite=1, RegDst=1; back to state 0 on cycle 5.
- LW with `waitrequest`=1 for 2 cycles in MEM_READ → states 0,1,6,7,7,7,8,0. MemRead=IorD=1 held throughout; RegWrite=1 and MemtoReg=1 only in state 8.
- BNE (000101) → state 10 with PCWriteCond=1, branch_ne=1, PCSource=01, ALUOp=01. With BEQ, branch_ne=0.
- JR (opcode 0, funct 001000) → states 0,1,12 with PCSource=11, PCWrite=1. J (000010) → state 11 with PCSource=10.
- `pc_zero`=1 in FETCH → MemRead=0, next state 13, `active`=0 and held 20 cycles. Pulse reset low → state 0, `active`=1.
